if_fetch_stage: RTL

//  Instruction-fetch stage that sits directly upstream of the decode logic in cpu.

---
 rtl/if_fetch_stage.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/if_fetch_stage.sv
// ============================================================================
// Module  : if_fetch_stage
// Brief   : Instruction fetch stage with PC, req/ready imem port and IF/ID reg.
// Revision: 1.0
// ============================================================================
`default_nettype none

module if_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall_i,
    input  logic        br_taken_i,
    input  logic [15:0] br_imm16_i,
    input  logic [31:0] br_pc4_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ready_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] if_id_inst_o,
    output logic [31:0] if_id_pc4_o,
    output logic        if_id_valid_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2,
        DROP = 2'd3
    } state_t;

    state_t      state, state_nxt;
    logic [31:0] pc, pc_nxt;
    logic [31:0] drop_addr, drop_addr_nxt;
    logic [31:0] hold_inst, hold_inst_nxt;
    logic [31:0] hold_pc4, hold_pc4_nxt;
    logic [31:0] inst_q, inst_nxt;
    logic [31:0] pc4_q, pc4_nxt;
    logic        valid_q, valid_nxt;

    logic [31:0] pc_plus4;
    logic [31:0] br_target;

    assign pc_plus4  = pc + 32'd4;
    assign br_target = br_pc4_i + {{14{br_imm16_i[15]}}, br_imm16_i, 2'b00};

    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            pc        <= RESET_PC;
            drop_addr <= RESET_PC;
            hold_inst <= 32'd0;
            hold_pc4  <= 32'd0;
            inst_q    <= NOP_INST;
            pc4_q     <= 32'd0;
            valid_q   <= 1'b0;
        end else begin
            state     <= state_nxt;
            pc        <= pc_nxt;
            drop_addr <= drop_addr_nxt;
            hold_inst <= hold_inst_nxt;
            hold_pc4  <= hold_pc4_nxt;
            inst_q    <= inst_nxt;
            pc4_q     <= pc4_nxt;
            valid_q   <= valid_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        pc_nxt        = pc;
        drop_addr_nxt = drop_addr;
        hold_inst_nxt = hold_inst;
        hold_pc4_nxt  = hold_pc4;
        inst_nxt      = inst_q;
        pc4_nxt       = pc4_q;
        valid_nxt     = valid_q;

        // A taken branch is older than anything in IF, so it flushes IF/ID
        // even while decode is stalled.
        if (br_taken_i && state != IDLE) begin
            pc_nxt    = br_target;
            inst_nxt  = NOP_INST;
            pc4_nxt   = 32'd0;
            valid_nxt = 1'b0;
        end

        case (state)
            IDLE: begin
                state_nxt = REQ;
            end
            REQ: begin
                if (br_taken_i) begin
                    if (!imem_ready_i) begin
                        drop_addr_nxt = pc;
                        state_nxt     = DROP;
                    end
                end else if (imem_ready_i) begin
                    if (stall_i) begin
                        hold_inst_nxt = imem_rdata_i;
                        hold_pc4_nxt  = pc_plus4;
                        state_nxt     = HOLD;
                    end else begin
                        inst_nxt  = imem_rdata_i;
                        pc4_nxt   = pc_plus4;
                        valid_nxt = 1'b1;
                        pc_nxt    = pc_plus4;
                    end
                end
            end
            HOLD: begin
                if (br_taken_i) begin
                    state_nxt = REQ;
                end else if (!stall_i) begin
                    inst_nxt  = hold_inst;
                    pc4_nxt   = hold_pc4;
                    valid_nxt = 1'b1;
                    pc_nxt    = pc_plus4;
                    state_nxt = REQ;
                end
            end
            DROP: begin
                // The abandoned request must still complete before a new one starts.
                if (imem_ready_i) begin
                    state_nxt = REQ;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign imem_req_o    = (state == REQ) || (state == DROP);
    assign imem_addr_o   = (state == DROP) ? drop_addr : pc;
    assign if_id_inst_o  = inst_q;
    assign if_id_pc4_o   = pc4_q;
    assign if_id_valid_o = valid_q;

endmodule

`default_nettype wire
